// File: rtl/conv3x3_sram_engine.sv
// rtl/conv3x3_sram_engine.sv - signed 3x3 convolution from dual-port source SRAM to destination SRAM; optional macro CONV_ABS_EN
module conv3x3_sram_engine #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 16,
   parameter int SHIFT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [35:0]       kernel,
   output logic              busy,
   output logic              done,
   output logic              src_ena,
   output logic              src_enb,
   output logic [ADDR_W-1:0] src_addra,
   output logic [ADDR_W-1:0] src_addrb,
   input  logic [7:0]        src_qa,
   input  logic [7:0]        src_qb,
   output logic              dst_en,
   output logic              dst_wen,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [7:0]        dst_d
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [2:0] {
      IDLE, RD0, RD1, RD2, RD3, RD4, ACC, WR
   } state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic signed [15:0]  acc_q, acc_d;
   logic                va_q, va_d;
   logic                vb_q, vb_d;
   logic [3:0]          ta_q, ta_d;
   logic [3:0]          tb_q, tb_d;
   logic                done_q, done_d;

   logic                last_col;
   logic                last_pix;
   logic [ADDR_W-1:0]   centre;
   logic                issue;
   logic                use_b;
   logic [3:0]          tap_a;
   logic [3:0]          tap_b;
   logic                ok_a;
   logic                ok_b;
   logic [ADDR_W-1:0]   addr_a;
   logic [ADDR_W-1:0]   addr_b;
   logic signed [15:0]  contrib_a;
   logic signed [15:0]  contrib_b;
   logic signed [15:0]  mag;
   logic signed [15:0]  shifted;
   logic [7:0]          result;

   // A neighbour is usable only when both its row and column fall inside the image.
   function automatic logic nb_ok(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                  input logic [3:0] idx);
      int  dr;
      int  dc;
      logic ok;
      dr = int'(idx) / 3;
      dc = int'(idx) % 3;
      ok = 1'b1;
      if (dr == 0 && r == '0) ok = 1'b0;
      if (dr == 2 && r == RW'(IMG_H - 1)) ok = 1'b0;
      if (dc == 0 && c == '0) ok = 1'b0;
      if (dc == 2 && c == CW'(IMG_W - 1)) ok = 1'b0;
      return ok;
   endfunction

   // Neighbour address as a signed offset from the centre; wrap only matters for
   // out-of-range slots, which never reach the port.
   function automatic logic [ADDR_W-1:0] nb_addr(input logic [ADDR_W-1:0] ctr,
                                                 input logic [3:0] idx);
      int off;
      off = (int'(idx) / 3 - 1) * IMG_W + (int'(idx) % 3 - 1);
      return ctr + ADDR_W'(off);
   endfunction

   // Unsigned pixel times signed tap, widened to accumulator width.
   function automatic logic signed [15:0] prod(input logic [7:0] px, input logic [3:0] tap);
      logic signed [15:0] a;
      logic signed [15:0] b;
      a = $signed({8'd0, px});
      b = $signed({{12{tap[3]}}, tap});
      return a * b;
   endfunction

   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_pix = last_col && (row_q == RW'(IMG_H - 1));
   assign centre   = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);

   // Tap pair issued on ports A/B in each read state.
   always_comb begin
      issue = 1'b1;
      use_b = 1'b1;
      tap_a = 4'd0;
      tap_b = 4'd1;
      case (state_q)
         RD0:     begin tap_a = 4'd0; tap_b = 4'd1; end
         RD1:     begin tap_a = 4'd2; tap_b = 4'd3; end
         RD2:     begin tap_a = 4'd4; tap_b = 4'd5; end
         RD3:     begin tap_a = 4'd6; tap_b = 4'd7; end
         RD4:     begin tap_a = 4'd8; tap_b = 4'd0; use_b = 1'b0; end
         default: begin issue = 1'b0; use_b = 1'b0; end
      endcase
   end

   assign ok_a   = nb_ok(row_q, col_q, tap_a);
   assign ok_b   = nb_ok(row_q, col_q, tap_b);
   assign addr_a = nb_addr(centre, tap_a);
   assign addr_b = nb_addr(centre, tap_b);

   assign src_ena   = issue && ok_a;
   assign src_enb   = use_b && ok_b;
   assign src_addra = src_ena ? addr_a : '0;
   assign src_addrb = src_enb ? addr_b : '0;

   // Padded slots contribute nothing; live slots use the data returned this cycle.
   assign contrib_a = va_q ? prod(src_qa, kernel[{ta_q, 2'b00} +: 4]) : 16'sd0;
   assign contrib_b = vb_q ? prod(src_qb, kernel[{tb_q, 2'b00} +: 4]) : 16'sd0;

   // Final scaling: optional magnitude, arithmetic shift, clamp to a pixel.
   always_comb begin
`ifdef CONV_ABS_EN
      mag = (acc_q < 16'sd0) ? -acc_q : acc_q;
`else
      mag = acc_q;
`endif
      shifted = mag >>> SHIFT;
      if (shifted < 16'sd0)
         result = 8'd0;
      else if (shifted > 16'sd255)
         result = 8'd255;
      else
         result = shifted[7:0];
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign dst_en   = (state_q == WR);
   assign dst_wen  = !dst_en;
   assign dst_addr = dst_en ? centre : '0;
   assign dst_d    = dst_en ? result : 8'd0;

   // Next-state logic: sequencing, raster counters, accumulator and slot pipeline.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      acc_d   = acc_q;
      done_d  = 1'b0;
      va_d    = src_ena;
      vb_d    = src_enb;
      ta_d    = tap_a;
      tb_d    = tap_b;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RD0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         RD0: begin
            acc_d   = 16'sd0;
            state_d = RD1;
         end
         RD1: begin
            acc_d   = acc_q + contrib_a + contrib_b;
            state_d = RD2;
         end
         RD2: begin
            acc_d   = acc_q + contrib_a + contrib_b;
            state_d = RD3;
         end
         RD3: begin
            acc_d   = acc_q + contrib_a + contrib_b;
            state_d = RD4;
         end
         RD4: begin
            acc_d   = acc_q + contrib_a + contrib_b;
            state_d = ACC;
         end
         ACC: begin
            acc_d   = acc_q + contrib_a + contrib_b;
            state_d = WR;
         end
         WR: begin
            if (last_pix) begin
               state_d = IDLE;
               done_d  = 1'b1;
               row_d   = '0;
               col_d   = '0;
            end else begin
               state_d = RD0;
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset; reset aborts a frame silently.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         acc_q   <= 16'sd0;
         va_q    <= 1'b0;
         vb_q    <= 1'b0;
         ta_q    <= 4'd0;
         tb_q    <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         acc_q   <= acc_d;
         va_q    <= va_d;
         vb_q    <= vb_d;
         ta_q    <= ta_d;
         tb_q    <= tb_d;
         done_q  <= done_d;
      end
   end

endmodule
